// File: rtl/riscv_nn_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract divider, one quotient bit per cycle.
// Operands are reduced to magnitudes at accept; signs are reapplied combinationally on output.
module riscv_nn_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [4:0]       rd_addr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_addr_o,
    output logic             busy_o
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready_o high unless killed
    // CALC  | iterating, one quotient bit per cycle
    // DONE  | result held until writeback takes it
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic             is_rem_q;
    logic [4:0]       tag_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] b_mag_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] rem_signed;

    always_comb begin
        a_neg      = ~op_i[0] & op_a_i[WIDTH-1];
        b_neg      = ~op_i[0] & op_b_i[WIDTH-1];
        a_mag      = a_neg ? -op_a_i : op_a_i;
        b_mag      = b_neg ? -op_b_i : op_b_i;
        // rem < |b| always holds, so WIDTH+1 bits cover the shifted remainder and the borrow
        rem_sh     = {rem_q, quo_q[WIDTH-1]};
        trial      = rem_sh - {1'b0, b_mag_q};
        quo_signed = neg_q_q ? -quo_q : quo_q;
        rem_signed = neg_r_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            is_rem_q <= 1'b0;
            tag_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_mag_q  <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (kill_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        is_rem_q <= op_i[1];
                        tag_q    <= rd_addr_i;
                        b_mag_q  <= b_mag;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        cnt_q    <= '0;
                        if (op_b_i == '0) begin
                            dz_q    <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= op_a_i;
                            state_q <= ST_DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE) && !kill_i;
        out_valid_o = (state_q == ST_DONE);
        busy_o      = (state_q != ST_IDLE);
        rd_addr_o   = tag_q;
        if (dz_q) begin
            result_o = is_rem_q ? rem_q : quo_q;
        end else begin
            result_o = is_rem_q ? rem_signed : quo_signed;
        end
    end

endmodule
